// File: rtl/mem_access_unit.sv
// Data-memory access engine for the memory stage.
// Byte-lane store/load alignment, AMO read-modify-write, flush drain.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ID_W-1:0]     in_id,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                stall,
  output logic                res_valid,
  output logic [DATA_W-1:0]   res_rdata,
  output logic                res_misaligned,
  output logic                dreq_valid,
  input  logic                dreq_ready,
  output logic                dreq_wen,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [DATA_W-1:0]   dreq_wdata,
  output logic [DATA_W/8-1:0] dreq_wstrb,
  input  logic                dresp_valid,
  input  logic [DATA_W-1:0]   dresp_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LWU  = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_SD   = 4'd11;
  localparam logic [3:0] OP_ADD  = 4'd13;
  localparam logic [3:0] OP_AND  = 4'd14;
  localparam logic [3:0] OP_OR   = 4'd15;

  typedef enum logic [2:0] {
    IDLE, REQ, RESP, AMO_WR, DRAIN
  } state_t;

  state_t           state;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [ID_W-1:0]  id_q;
  logic [3:0]       op_q;
  logic [OFF_W-1:0] off_q;
  logic [31:0]      amo_src;

  function automatic logic [1:0] size_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8: size_of = 2'd0;
      4'd3, 4'd4, 4'd9: size_of = 2'd1;
      4'd7, 4'd11:      size_of = 2'd3;
      default:          size_of = 2'd2;
    endcase
  endfunction

  logic [3:0]       op_eff;
  logic [1:0]       sz_in;
  logic [OFF_W-1:0] off_in;
  logic             mis;
  logic             st_in;
  logic [NB-1:0]    strb_in;
  logic             go;

  always_comb begin
    op_eff = in_op;
    if (DATA_W == 32 &&
        (in_op == OP_LWU || in_op == OP_LD || in_op == OP_SD))
      op_eff = OP_NONE;
    sz_in  = size_of(op_eff);
    off_in = in_addr[OFF_W-1:0];
    st_in  = op_eff[3:2] == 2'b10;
    case (sz_in)
      2'd0: begin mis = 1'b0;          strb_in = NB'(1);  end
      2'd1: begin mis = in_addr[0];    strb_in = NB'(3);  end
      2'd2: begin mis = |in_addr[1:0]; strb_in = NB'(15); end
      default: begin
        mis     = |in_addr[2:0];
        strb_in = '1;
      end
    endcase
    strb_in = strb_in << off_in;
  end

  assign go = in_valid && op_eff != OP_NONE &&
              !(done && done_id == in_id);
  assign stall = go || state != IDLE;
  assign res_valid = done && done_id == in_id;

  logic              uns_q;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] amo_old;
  logic [DATA_W-1:0] amo_wr;
  logic [31:0]       amo_new;

  assign uns_q = op_q == OP_LBU || op_q == OP_LHU ||
                 op_q == OP_LWU;

  always_comb begin
    lane = dresp_rdata >> {off_q, 3'b000};
    case (size_of(op_q))
      2'd0: ld_ext = uns_q ? DATA_W'(lane[7:0])
                           : DATA_W'($signed(lane[7:0]));
      2'd1: ld_ext = uns_q ? DATA_W'(lane[15:0])
                           : DATA_W'($signed(lane[15:0]));
      2'd2: ld_ext = uns_q ? DATA_W'(lane[31:0])
                           : DATA_W'($signed(lane[31:0]));
      default: ld_ext = lane;
    endcase
    amo_old = DATA_W'($signed(lane[31:0]));
    case (op_q)
      OP_ADD:  amo_new = lane[31:0] + amo_src;
      OP_AND:  amo_new = lane[31:0] & amo_src;
      OP_OR:   amo_new = lane[31:0] | amo_src;
      default: amo_new = amo_src;
    endcase
    amo_wr = DATA_W'(amo_new) << {off_q, 3'b000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      done_id        <= '1;
      id_q           <= '0;
      op_q           <= OP_NONE;
      off_q          <= '0;
      amo_src        <= '0;
      res_rdata      <= '0;
      res_misaligned <= 1'b0;
      dreq_valid     <= 1'b0;
      dreq_wen       <= 1'b0;
      dreq_addr      <= '0;
      dreq_wdata     <= '0;
      dreq_wstrb     <= '0;
    end else begin
      unique case (state)
        IDLE: if (go && !flush) begin
          done           <= 1'b0;
          res_misaligned <= 1'b0;
          id_q           <= in_id;
          op_q           <= op_eff;
          off_q          <= off_in;
          amo_src        <= in_wdata[31:0];
          if (mis) begin
            done           <= 1'b1;
            done_id        <= in_id;
            res_misaligned <= 1'b1;
          end else begin
            state      <= REQ;
            dreq_valid <= 1'b1;
            dreq_wen   <= st_in;
            dreq_addr  <= {in_addr[ADDR_W-1:OFF_W],
                           {OFF_W{1'b0}}};
            dreq_wdata <= st_in ? in_wdata << {off_in, 3'b000}
                                : '0;
            dreq_wstrb <= st_in ? strb_in : '0;
          end
        end
        REQ: if (flush || dreq_ready) begin
          dreq_valid <= 1'b0;
          dreq_wen   <= 1'b0;
          // an accepted read still owes us a response
          if (flush)
            state <= (dreq_ready && !dreq_wen) ? DRAIN : IDLE;
          else if (dreq_wen) begin
            state   <= IDLE;
            done    <= 1'b1;
            done_id <= id_q;
          end else
            state <= RESP;
        end
        RESP: if (dresp_valid) begin
          if (flush)
            state <= IDLE;
          else if (op_q[3:2] == 2'b11) begin
            res_rdata  <= amo_old;
            state      <= AMO_WR;
            dreq_valid <= 1'b1;
            dreq_wen   <= 1'b1;
            dreq_wdata <= amo_wr;
            dreq_wstrb <= NB'(15) << off_q;
          end else begin
            res_rdata <= ld_ext;
            state     <= IDLE;
            done      <= 1'b1;
            done_id   <= id_q;
          end
        end else if (flush)
          state <= DRAIN;
        AMO_WR: if (flush || dreq_ready) begin
          dreq_valid <= 1'b0;
          dreq_wen   <= 1'b0;
          state      <= IDLE;
          if (!flush) begin
            done    <= 1'b1;
            done_id <= id_q;
          end
        end
        DRAIN: if (dresp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// 32-bit and 64-bit instances share clock and reset.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_valid, a_flush, a_stall, a_res_valid, a_mis;
  logic [63:0] a_id;
  logic [3:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_res_rdata;
  logic        a_rq_valid, a_rq_ready, a_rq_wen, a_rs_valid;
  logic [31:0] a_rq_addr, a_rq_wdata, a_rs_rdata;
  logic [3:0]  a_rq_wstrb;

  logic        b_valid, b_flush, b_stall, b_res_valid, b_mis;
  logic [63:0] b_id;
  logic [3:0]  b_op;
  logic [31:0] b_addr, b_rq_addr;
  logic [63:0] b_wdata, b_res_rdata, b_rq_wdata, b_rs_rdata;
  logic        b_rq_valid, b_rq_ready, b_rq_wen, b_rs_valid;
  logic [7:0]  b_rq_wstrb;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ID_W(64)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_valid), .in_id(a_id), .in_op(a_op),
    .in_addr(a_addr), .in_wdata(a_wdata), .flush(a_flush),
    .stall(a_stall), .res_valid(a_res_valid),
    .res_rdata(a_res_rdata), .res_misaligned(a_mis),
    .dreq_valid(a_rq_valid), .dreq_ready(a_rq_ready),
    .dreq_wen(a_rq_wen), .dreq_addr(a_rq_addr),
    .dreq_wdata(a_rq_wdata), .dreq_wstrb(a_rq_wstrb),
    .dresp_valid(a_rs_valid), .dresp_rdata(a_rs_rdata)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .ID_W(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_valid), .in_id(b_id), .in_op(b_op),
    .in_addr(b_addr), .in_wdata(b_wdata), .flush(b_flush),
    .stall(b_stall), .res_valid(b_res_valid),
    .res_rdata(b_res_rdata), .res_misaligned(b_mis),
    .dreq_valid(b_rq_valid), .dreq_ready(b_rq_ready),
    .dreq_wen(b_rq_wen), .dreq_addr(b_rq_addr),
    .dreq_wdata(b_rq_wdata), .dreq_wstrb(b_rq_wstrb),
    .dresp_valid(b_rs_valid), .dresp_rdata(b_rs_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (a_rq_valid !== 1'b0 || a_rq_wen !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: valid %b wen %b exp 0 0",
               a_rq_valid, a_rq_wen);
    end
    checks++;
    if (a_rq_addr !== 32'h0 || a_rq_wdata !== 32'h0 ||
        a_rq_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL rst_fields: addr %h wdata %h wstrb %h exp 0",
               a_rq_addr, a_rq_wdata, a_rq_wstrb);
    end
    checks++;
    if (a_res_valid !== 1'b0 || a_res_rdata !== 32'h0 ||
        a_mis !== 1'b0 || a_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_res: rv %b rd %h mis %b stall %b exp 0",
               a_res_valid, a_res_rdata, a_mis, a_stall);
    end
    checks++;
    if (b_rq_valid !== 1'b0 || b_res_rdata !== 64'h0) begin
      errors++;
      $display("FAIL rst_b: valid %b rd %h exp 0 0",
               b_rq_valid, b_res_rdata);
    end
  endtask

  task automatic test_store();
    int reqs;
    a_valid = 1'b1; a_id = 64'd1; a_op = 4'd10;
    a_addr = 32'h104; a_wdata = 32'hDEADBEEF; a_rq_ready = 1'b1;
    #1;
    checks++;
    if (a_stall !== 1'b1 || a_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_start: stall %b rv %b exp 1 0",
               a_stall, a_res_valid);
    end
    tick();
    checks++;
    if (a_rq_valid !== 1'b1 || a_rq_wen !== 1'b1 ||
        a_rq_addr !== 32'h104 || a_rq_wstrb !== 4'hF ||
        a_rq_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_req: v%b w%b a%h s%h d%h exp 1 1 104 f deadbeef",
               a_rq_valid, a_rq_wen, a_rq_addr, a_rq_wstrb,
               a_rq_wdata);
    end
    tick();
    checks++;
    if (a_res_valid !== 1'b1 || a_stall !== 1'b0 ||
        a_rq_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_done: rv %b stall %b dv %b exp 1 0 0",
               a_res_valid, a_stall, a_rq_valid);
    end
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_rq_valid) reqs++;
    end
    checks++;
    if (reqs !== 0 || a_res_valid !== 1'b1) begin
      errors++;
      $display("FAIL sw_hold: reqs %0d rv %b exp 0 1",
               reqs, a_res_valid);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_load64();
    logic [3:0]  ops [2];
    logic [63:0] exp [2];
    ops[0] = 4'd1; exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ops[1] = 4'd2; exp[1] = 64'h0000_0000_0000_0080;
    for (int i = 0; i < 2; i++) begin
      b_valid = 1'b1; b_id = 64'd2 + 64'(i); b_op = ops[i];
      b_addr = 32'h1005; b_rq_ready = 1'b1;
      tick();
      checks++;
      if (b_rq_valid !== 1'b1 || b_rq_wen !== 1'b0 ||
          b_rq_addr !== 32'h1000) begin
        errors++;
        $display("FAIL lb64_req%0d: v %b w %b a %h exp 1 0 1000",
                 i, b_rq_valid, b_rq_wen, b_rq_addr);
      end
      tick();
      b_rs_valid = 1'b1; b_rs_rdata = 64'h0000_8000_0000_0000;
      tick();
      b_rs_valid = 1'b0;
      checks++;
      if (b_res_valid !== 1'b1 || b_res_rdata !== exp[i]) begin
        errors++;
        $display("FAIL lb64_data%0d: rv %b rd %h exp 1 %h",
                 i, b_res_valid, b_res_rdata, exp[i]);
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    a_valid = 1'b1; a_id = 64'd4; a_op = 4'd3;
    a_addr = 32'h2003; a_rq_ready = 1'b1;
    tick();
    checks++;
    if (a_res_valid !== 1'b1 || a_mis !== 1'b1 ||
        a_rq_valid !== 1'b0 || a_stall !== 1'b0) begin
      errors++;
      $display("FAIL lh_mis: rv %b mis %b dv %b stall %b exp 1 1 0 0",
               a_res_valid, a_mis, a_rq_valid, a_stall);
    end
    a_id = 64'd5; a_op = 4'd9;
    a_addr = 32'h2002; a_wdata = 32'h0000ABCD;
    #1;
    checks++;
    if (a_res_valid !== 1'b0 || a_stall !== 1'b1) begin
      errors++;
      $display("FAIL sh_start: rv %b stall %b exp 0 1",
               a_res_valid, a_stall);
    end
    tick();
    checks++;
    if (a_mis !== 1'b0 || a_rq_valid !== 1'b1 ||
        a_rq_wstrb !== 4'b1100 || a_rq_wdata !== 32'hABCD0000 ||
        a_rq_addr !== 32'h2000) begin
      errors++;
      $display("FAIL sh_req: mis %b v %b s %b d %h a %h exp 0 1 1100 abcd0000 2000",
               a_mis, a_rq_valid, a_rq_wstrb, a_rq_wdata, a_rq_addr);
    end
    tick();
    checks++;
    if (a_res_valid !== 1'b1 || a_mis !== 1'b0) begin
      errors++;
      $display("FAIL sh_done: rv %b mis %b exp 1 0",
               a_res_valid, a_mis);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_amo();
    a_valid = 1'b1; a_id = 64'd6; a_op = 4'd13;
    a_addr = 32'h300; a_wdata = 32'd2; a_rq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_rq_valid !== 1'b1 || a_rq_wen !== 1'b0 ||
          a_rq_addr !== 32'h300 || a_stall !== 1'b1) begin
        errors++;
        $display("FAIL amo_hold%0d: v %b w %b a %h st %b exp 1 0 300 1",
                 i, a_rq_valid, a_rq_wen, a_rq_addr, a_stall);
      end
    end
    a_rq_ready = 1'b1;
    tick();
    a_rs_valid = 1'b1; a_rs_rdata = 32'hFFFFFFFF;
    tick();
    a_rs_valid = 1'b0;
    checks++;
    if (a_rq_valid !== 1'b1 || a_rq_wen !== 1'b1 ||
        a_rq_wdata !== 32'h1 || a_rq_wstrb !== 4'hF ||
        a_rq_addr !== 32'h300 || a_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL amo_wr: v%b w%b d%h s%h a%h rv%b exp 1 1 1 f 300 0",
               a_rq_valid, a_rq_wen, a_rq_wdata, a_rq_wstrb,
               a_rq_addr, a_res_valid);
    end
    tick();
    checks++;
    if (a_res_valid !== 1'b1 || a_res_rdata !== 32'hFFFFFFFF ||
        a_rq_valid !== 1'b0) begin
      errors++;
      $display("FAIL amo_done: rv %b rd %h dv %b exp 1 ffffffff 0",
               a_res_valid, a_res_rdata, a_rq_valid);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_flush_drain();
    a_valid = 1'b1; a_id = 64'd7; a_op = 4'd5;
    a_addr = 32'h400; a_rq_ready = 1'b1;
    tick();
    tick();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_id = 64'd8; a_addr = 32'h404;
    tick();
    checks++;
    if (a_stall !== 1'b1 || a_rq_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_wait: stall %b dv %b exp 1 0",
               a_stall, a_rq_valid);
    end
    a_rs_valid = 1'b1; a_rs_rdata = 32'h11111111;
    tick();
    a_rs_valid = 1'b0;
    checks++;
    if (a_rq_valid !== 1'b0 || a_res_valid !== 1'b0 ||
        a_res_rdata !== 32'hFFFFFFFF || a_stall !== 1'b1) begin
      errors++;
      $display("FAIL drain_discard: dv %b rv %b rd %h st %b exp 0 0 ffffffff 1",
               a_rq_valid, a_res_valid, a_res_rdata, a_stall);
    end
    tick();
    checks++;
    if (a_rq_valid !== 1'b1 || a_rq_addr !== 32'h404) begin
      errors++;
      $display("FAIL drain_newreq: dv %b a %h exp 1 404",
               a_rq_valid, a_rq_addr);
    end
    tick();
    a_rs_valid = 1'b1; a_rs_rdata = 32'h22222222;
    tick();
    a_rs_valid = 1'b0;
    checks++;
    if (a_res_valid !== 1'b1 || a_res_rdata !== 32'h22222222) begin
      errors++;
      $display("FAIL drain_newdata: rv %b rd %h exp 1 22222222",
               a_res_valid, a_res_rdata);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset_amo();
    a_valid = 1'b1; a_id = 64'd9; a_op = 4'd12;
    a_addr = 32'h500; a_wdata = 32'h12345678; a_rq_ready = 1'b1;
    tick();
    tick();
    a_rs_valid = 1'b1; a_rs_rdata = 32'hAAAAAAAA;
    tick();
    a_rs_valid = 1'b0; a_rq_ready = 1'b0;
    checks++;
    if (a_rq_valid !== 1'b1 || a_rq_wen !== 1'b1 ||
        a_rq_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL swap_wr: v %b w %b d %h exp 1 1 12345678",
               a_rq_valid, a_rq_wen, a_rq_wdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_rq_valid !== 1'b0 || a_res_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_rst: dv %b rd %h exp 0 0",
               a_rq_valid, a_res_rdata);
    end
    tick();
    rst_n = 1'b1; a_rq_ready = 1'b1;
    #1;
    checks++;
    if (a_stall !== 1'b1 || a_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rerun: stall %b rv %b exp 1 0",
               a_stall, a_res_valid);
    end
    tick();
    checks++;
    if (a_rq_valid !== 1'b1 || a_rq_wen !== 1'b0 ||
        a_rq_addr !== 32'h500) begin
      errors++;
      $display("FAIL rerun_req: v %b w %b a %h exp 1 0 500",
               a_rq_valid, a_rq_wen, a_rq_addr);
    end
    tick();
    a_rs_valid = 1'b1; a_rs_rdata = 32'hBBBBBBBB;
    tick();
    a_rs_valid = 1'b0;
    tick();
    checks++;
    if (a_res_valid !== 1'b1 || a_res_rdata !== 32'hBBBBBBBB) begin
      errors++;
      $display("FAIL rerun_done: rv %b rd %h exp 1 bbbbbbbb",
               a_res_valid, a_res_rdata);
    end
    a_valid = 1'b0;
  endtask

  initial begin
    a_valid = 0; a_id = '0; a_op = '0; a_addr = '0; a_wdata = '0;
    a_flush = 0; a_rq_ready = 0; a_rs_valid = 0; a_rs_rdata = '0;
    b_valid = 0; b_id = '0; b_op = '0; b_addr = '0; b_wdata = '0;
    b_flush = 0; b_rq_ready = 0; b_rs_valid = 0; b_rs_rdata = '0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_store();
    test_load64();
    test_misaligned();
    test_amo();
    test_flush_drain();
    test_reset_amo();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
